// File: rtl/cnn_accel_pkg.sv
// cnn_accel_pkg: shared types and constants for the convolution accumulator stage
package cnn_accel_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int BEAT_WIDTH = 8;
    localparam logic [BEAT_WIDTH-1:0] BEAT_CNT_RST = '0;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;
endpackage

// File: rtl/conv_window_accumulator_if.sv
// conv_window_accumulator_if: control, input-beat and result handshake bundle
interface conv_window_accumulator_if #(
    parameter int DATA_WIDTH = cnn_accel_pkg::DATA_WIDTH,
    parameter int BEAT_WIDTH = cnn_accel_pkg::BEAT_WIDTH
);
    logic                  start;
    logic [BEAT_WIDTH-1:0] beats;
    logic [DATA_WIDTH-1:0] bias;
    logic                  abort;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  busy;
    modport master (
        output start, beats, bias, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  start, beats, bias, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/conv_window_accumulator_beat_counter.sv
// beat_counter: loadable down-counter flagging the final beat of a window
module beat_counter
    import cnn_accel_pkg::*;
#(
    parameter int WIDTH = BEAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             last
);
    logic [WIDTH-1:0] remaining;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            remaining <= WIDTH'(BEAT_CNT_RST);
        else if (load)
            remaining <= value;
        else if (dec)
            remaining <= remaining - WIDTH'(1);
    end
    assign last = remaining == WIDTH'(1);
endmodule

// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator: sums a programmed number of partial sums onto a bias
module conv_window_accumulator #(
    parameter int DATA_WIDTH = cnn_accel_pkg::DATA_WIDTH,
    parameter int BEAT_WIDTH = cnn_accel_pkg::BEAT_WIDTH
) (
    input logic                      clk,
    input logic                      rst_n,
    conv_window_accumulator_if.slave bus
);
    import cnn_accel_pkg::*;
    acc_state_t state, next_state;
    logic [DATA_WIDTH-1:0] acc;
    logic load, take, last;
    // abort suppresses both the window load and any beat arriving with it
    assign load = state == IDLE && bus.start && !bus.abort;
    assign take = state == ACCUM && bus.in_valid && !bus.abort;
    beat_counter #(.WIDTH(BEAT_WIDTH)) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .dec   (take),
        .value (bus.beats),
        .last  (last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_comb begin
        next_state = state;
        if (bus.abort)
            next_state = IDLE;
        else
            case (state)
                IDLE:    next_state = load ? (bus.beats != '0 ? ACCUM : HOLD) : IDLE;
                ACCUM:   next_state = take && last ? HOLD : ACCUM;
                HOLD:    next_state = bus.out_ready ? IDLE : HOLD;
                default: next_state = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (load)
            acc <= bus.bias;
        else if (take)
            acc <= acc + bus.in_data;
    end
    assign bus.in_ready  = state == ACCUM;
    assign bus.out_valid = state == HOLD;
    assign bus.busy      = state != IDLE;
    assign bus.out_data  = acc;
endmodule

// File: tb/tb_conv_window_accumulator.sv
// tb_conv_window_accumulator: directed plus randomized windows against a sum model
module tb_conv_window_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    conv_window_accumulator_if #(.DATA_WIDTH(16), .BEAT_WIDTH(8)) bus ();
    conv_window_accumulator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.beats = 0; bus.bias = 0; bus.abort = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    endtask

    // Expected result is the bias plus every accepted beat, modulo 2^16.
    task automatic run_window(input logic [15:0] b, input logic [7:0] n,
                              input logic [15:0] d[$], input bit vp[$], input int stall);
        logic [15:0] exp_sum;
        int k, t;
        exp_sum = b;
        k = 0;
        t = 0;
        bus.start = 1; bus.beats = n; bus.bias = b;
        step();
        bus.start = 0;
        check("busy_after_start", bus.busy, 1);
        while (k < n) begin
            check("in_ready_accum", bus.in_ready, 1);
            check("no_early_valid", bus.out_valid, 0);
            bus.in_valid = (t < vp.size()) ? vp[t] : 1'b1;
            bus.in_data = d[k];
            t++;
            step();
            if (bus.in_valid) begin
                exp_sum += d[k];
                k++;
            end
            if (t > 1000) begin
                check("beat_timeout", k, n);
                break;
            end
        end
        bus.in_valid = 0;
        check("out_valid", bus.out_valid, 1);
        check("in_ready_hold", bus.in_ready, 0);
        check("out_data", bus.out_data, exp_sum);
        repeat (stall) begin
            bus.out_ready = 0;
            bus.start = 1;
            step();
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, exp_sum);
        end
        bus.start = 0;
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        check("idle_after_hs_busy", bus.busy, 0);
        check("idle_after_hs_valid", bus.out_valid, 0);
        step();
        check("no_second_window", bus.busy, 0);
    endtask

    initial begin
        logic [15:0] dq[$];
        bit vq[$];
        logic [7:0] n;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        #2 rst_n = 1;
        step();
        check("idle_busy", bus.busy, 0);

        dq.delete(); vq.delete();
        dq.push_back(16'h0001); dq.push_back(16'h0002); dq.push_back(16'h0003); dq.push_back(16'h0004);
        run_window(16'h0005, 8'd4, dq, vq, 0);

        dq.delete(); dq.push_back(16'h0002);
        run_window(16'hFFFF, 8'd1, dq, vq, 0);
        dq.delete(); dq.push_back(16'h8000);
        run_window(16'h8000, 8'd1, dq, vq, 0);

        dq.delete();
        run_window(16'h1234, 8'd0, dq, vq, 1);

        dq.delete(); dq.push_back(16'd10); dq.push_back(16'd20); dq.push_back(16'd30);
        vq.push_back(1); vq.push_back(0); vq.push_back(1);
        vq.push_back(0); vq.push_back(0); vq.push_back(1);
        run_window(16'h0000, 8'd3, dq, vq, 3);
        vq.delete();

        // abort together with the third beat
        bus.start = 1; bus.beats = 4; bus.bias = 16'h0055;
        step();
        bus.start = 0;
        bus.in_valid = 1; bus.in_data = 16'h0011;
        step();
        step();
        bus.abort = 1;
        step();
        bus.abort = 0; bus.in_valid = 0;
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_no_valid", bus.out_valid, 0);
        step();
        check("abort_still_idle", bus.out_valid, 0);
        dq.delete(); dq.push_back(16'h0007);
        run_window(16'h0000, 8'd1, dq, vq, 0);

        // abort in HOLD beats a simultaneous handshake
        bus.start = 1; bus.beats = 0; bus.bias = 16'h0009;
        step();
        bus.start = 0;
        check("hold_valid", bus.out_valid, 1);
        bus.abort = 1; bus.out_ready = 1;
        step();
        bus.abort = 0; bus.out_ready = 0;
        check("hold_abort_valid", bus.out_valid, 0);
        check("hold_abort_busy", bus.busy, 0);

        bus.start = 1; bus.abort = 1;
        step();
        bus.start = 0; bus.abort = 0;
        check("start_abort_idle", bus.busy, 0);

        // asynchronous reset between edges in ACCUM
        bus.start = 1; bus.beats = 5; bus.bias = 16'h0003;
        step();
        bus.start = 0;
        bus.in_valid = 1; bus.in_data = 16'h0001;
        step();
        bus.in_valid = 0;
        #2 rst_n = 0;
        #1;
        check("async_busy", bus.busy, 0);
        check("async_in_ready", bus.in_ready, 0);
        check("async_out_valid", bus.out_valid, 0);
        check("async_out_data", bus.out_data, 0);
        @(posedge clk);
        #3 rst_n = 1;
        dq.delete(); dq.push_back(16'h0100); dq.push_back(16'h0020);
        run_window(16'h0004, 8'd2, dq, vq, 0);

        for (int w = 0; w < 30; w++) begin
            dq.delete(); vq.delete();
            n = 8'($urandom_range(0, 12));
            for (int i = 0; i < n; i++) dq.push_back(16'($urandom));
            for (int i = 0; i < 40; i++) vq.push_back($urandom_range(0, 9) < 7);
            run_window(16'($urandom), n, dq, vq, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
